// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal sensor hub and the power manager
// that consumes its outputs.
package thermal_pkg;

  localparam int TEMP_W = 16;

  typedef logic [TEMP_W-1:0] temp_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    UPD,
    END,
    GAP
  } state_e;

  localparam temp_t DEFAULT_WARN_THRESHOLD = 16'h5000;
  localparam temp_t DEFAULT_CRIT_THRESHOLD = 16'h5800;
  localparam temp_t DEFAULT_HYST           = 16'h0200;

endpackage

// File: rtl/thermal_sensor_hub_if.sv
// Request/valid handshake between the hub (master) and the on-die sensor mux (slave).
interface thermal_sensor_hub_if #(
  parameter int NUM_DOMAINS = 8,
  parameter int TEMP_W      = 16
) ();

  logic                           sens_req;
  logic [$clog2(NUM_DOMAINS)-1:0] sens_sel;
  logic                           sens_valid;
  logic [TEMP_W-1:0]              sens_data;

  modport master (
    output sens_req,
    output sens_sel,
    input  sens_valid,
    input  sens_data
  );

  modport slave (
    input  sens_req,
    input  sens_sel,
    output sens_valid,
    output sens_data
  );

endinterface

// File: rtl/thermal_threshold_tracker.sv
// Persistence counter plus hysteresis flag, evaluated once per scan on the hottest temperature.
module thermal_threshold_tracker #(
  parameter int                TEMP_W  = 16,
  parameter int                PERSIST = 4,
  parameter logic [TEMP_W-1:0] HYST    = 16'h0200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eval_i,
  input  logic [TEMP_W-1:0] value_i,
  input  logic [TEMP_W-1:0] threshold_i,
  output logic              flag_o
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic [TEMP_W-1:0] clear_level;

  assign clear_level = (threshold_i > HYST) ? (threshold_i - HYST) : '0;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (value_i > threshold_i) begin
      if (cnt_q != CNT_W'(PERSIST)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_W'(PERSIST)) begin
        flag_d = 1'b1;
      end
    end else if (value_i < clear_level) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      // Inside the hysteresis band the flag holds but the run of hot scans is broken.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (eval_i) begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/thermal_sensor_hub.sv
// Round-robin thermal sensor scanner with per-domain IIR filtering, hottest-domain
// selection, qualified warning/emergency flags and sensor timeout detection.
module thermal_sensor_hub
  import thermal_pkg::*;
#(
  parameter int                NUM_DOMAINS     = 8,
  parameter int                TEMP_W          = 16,
  parameter int                SAMPLE_INTERVAL = 64,
  parameter int                FILTER_SHIFT    = 2,
  parameter int                PERSIST         = 4,
  parameter logic [TEMP_W-1:0] HYST            = TEMP_W'(DEFAULT_HYST),
  parameter int                TIMEOUT         = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  thermal_sensor_hub_if.master                   sens,
  input  logic [TEMP_W-1:0]                      temp_threshold_warning,
  input  logic [TEMP_W-1:0]                      temp_threshold_critical,
  output logic [NUM_DOMAINS-1:0][TEMP_W-1:0]     temperature,
  output logic [TEMP_W-1:0]                      temp_max,
  output logic [$clog2(NUM_DOMAINS)-1:0]         temp_max_idx,
  output logic                                   thermal_warning,
  output logic                                   thermal_emergency,
  output logic [NUM_DOMAINS-1:0]                 sensor_fault,
  output logic                                   scan_done
);

  localparam int SEL_W  = $clog2(NUM_DOMAINS);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int GCNT_W = $clog2(SAMPLE_INTERVAL + 1);

  state_e                            state_q;
  logic [SEL_W-1:0]                  sel_q;
  logic [WCNT_W-1:0]                 wait_cnt_q;
  logic [GCNT_W-1:0]                 gap_cnt_q;
  logic                              got_q;
  logic [TEMP_W-1:0]                 sample_q;
  logic [NUM_DOMAINS-1:0]            primed_q;
  logic [NUM_DOMAINS-1:0][TEMP_W-1:0] temp_q;
  logic [NUM_DOMAINS-1:0]            fault_q;
  logic                              req_q;
  logic [TEMP_W-1:0]                 max_q, max_d;
  logic [SEL_W-1:0]                  idx_q, idx_d;
  logic                              all_fault_q, all_fault_d;
  logic                              scan_done_q;
  logic                              warn_flag, crit_flag;
  logic                              eval_end;

  logic signed [TEMP_W:0]            diff;
  logic [TEMP_W-1:0]                 filtered;

  // Extra sign bit keeps sample - temp exact; the shifted step always lands back in range.
  assign diff     = $signed({1'b0, sample_q}) - $signed({1'b0, temp_q[sel_q]});
  assign filtered = primed_q[sel_q] ? (temp_q[sel_q] + TEMP_W'(diff >>> FILTER_SHIFT))
                                    : sample_q;

  always_comb begin
    logic any_ok;
    any_ok = 1'b0;
    max_d  = '0;
    idx_d  = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (!fault_q[i] && (!any_ok || temp_q[i] > max_d)) begin
        max_d  = temp_q[i];
        idx_d  = SEL_W'(i);
        any_ok = 1'b1;
      end
    end
    all_fault_d = !any_ok;
    if (!any_ok) begin
      max_d = '1;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      got_q       <= 1'b0;
      sample_q    <= '0;
      primed_q    <= '0;
      temp_q      <= '0;
      fault_q     <= '0;
      req_q       <= 1'b0;
      max_q       <= '0;
      idx_q       <= '0;
      all_fault_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      req_q       <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            sel_q   <= '0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          wait_cnt_q <= '0;
          got_q      <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (sens.sens_valid) begin
            sample_q <= sens.sens_data;
            got_q    <= 1'b1;
            state_q  <= UPD;
          end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
            state_q <= UPD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        UPD: begin
          if (got_q) begin
            temp_q[sel_q]   <= filtered;
            primed_q[sel_q] <= 1'b1;
            fault_q[sel_q]  <= 1'b0;
          end else begin
            fault_q[sel_q]  <= 1'b1;
          end
          if (sel_q == SEL_W'(NUM_DOMAINS - 1)) begin
            state_q <= END;
          end else begin
            sel_q   <= sel_q + 1'b1;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        END: begin
          max_q       <= max_d;
          idx_q       <= idx_d;
          all_fault_q <= all_fault_d;
          scan_done_q <= 1'b1;
          sel_q       <= '0;
          gap_cnt_q   <= '0;
          state_q     <= GAP;
        end
        GAP: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (gap_cnt_q == GCNT_W'(SAMPLE_INTERVAL - 1)) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eval_end = (state_q == END);

  thermal_threshold_tracker #(
    .TEMP_W (TEMP_W),
    .PERSIST(PERSIST),
    .HYST   (HYST)
  ) u_warn_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .eval_i     (eval_end),
    .value_i    (max_d),
    .threshold_i(temp_threshold_warning),
    .flag_o     (warn_flag)
  );

  thermal_threshold_tracker #(
    .TEMP_W (TEMP_W),
    .PERSIST(PERSIST),
    .HYST   (HYST)
  ) u_crit_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .eval_i     (eval_end),
    .value_i    (max_d),
    .threshold_i(temp_threshold_critical),
    .flag_o     (crit_flag)
  );

  assign sens.sens_req     = req_q;
  assign sens.sens_sel     = sel_q;
  assign temperature       = temp_q;
  assign temp_max          = max_q;
  assign temp_max_idx      = idx_q;
  assign thermal_warning   = warn_flag;
  // With every sensor silent the power manager must assume the worst for that scan.
  assign thermal_emergency = crit_flag | all_fault_q;
  assign sensor_fault      = fault_q;
  assign scan_done         = scan_done_q;

endmodule

// File: tb/tb_thermal_sensor_hub.sv
// Randomized self-checking bench for thermal_sensor_hub against a scan-level reference model.
module tb_thermal_sensor_hub;

  localparam int ND      = 8;
  localparam int TW      = 16;
  localparam int SI      = 64;
  localparam int FS      = 2;
  localparam int PERSIST = 4;
  localparam int HYST    = 'h0200;
  localparam int TIMEOUT = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [TW-1:0]           warnThr;
  logic [TW-1:0]           critThr;
  logic [ND-1:0][TW-1:0]   temperature;
  logic [TW-1:0]           temp_max;
  logic [$clog2(ND)-1:0]   temp_max_idx;
  logic                    thermal_warning;
  logic                    thermal_emergency;
  logic [ND-1:0]           sensor_fault;
  logic                    scan_done;

  thermal_sensor_hub_if #(.NUM_DOMAINS(ND), .TEMP_W(TW)) sensIf ();

  thermal_sensor_hub #(
    .NUM_DOMAINS    (ND),
    .TEMP_W         (TW),
    .SAMPLE_INTERVAL(SI),
    .FILTER_SHIFT   (FS),
    .PERSIST        (PERSIST),
    .HYST           (TW'(HYST)),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .sens                   (sensIf),
    .temp_threshold_warning (warnThr),
    .temp_threshold_critical(critThr),
    .temperature            (temperature),
    .temp_max               (temp_max),
    .temp_max_idx           (temp_max_idx),
    .thermal_warning        (thermal_warning),
    .thermal_emergency      (thermal_emergency),
    .sensor_fault           (sensor_fault),
    .scan_done              (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Sensor behaviour: latency 0 = silent, 1..TIMEOUT = answers in time, larger = too late.
  logic [TW-1:0] sensorData [ND];
  int            sensorLat  [ND];
  int            reqCount = 0;

  // Scan-level reference state.
  int  mTemp   [ND];
  bit  mPrimed [ND];
  bit  mFault  [ND];
  int  mCnt    [2];
  bit  mFlag   [2];
  bit  mAllFault;
  int  mMax;
  int  mIdx;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ND; i++) begin
      mTemp[i] = 0; mPrimed[i] = 0; mFault[i] = 0;
    end
    mCnt[0] = 0; mCnt[1] = 0; mFlag[0] = 0; mFlag[1] = 0;
    mAllFault = 0; mMax = 0; mIdx = 0;
  endtask

  task automatic modelTracker(input int k, input int thr);
    int clr;
    clr = (thr > HYST) ? thr - HYST : 0;
    if (mMax > thr) begin
      mCnt[k] = (mCnt[k] + 1 > PERSIST) ? PERSIST : mCnt[k] + 1;
      if (mCnt[k] == PERSIST) mFlag[k] = 1;
    end else if (mMax < clr) begin
      mCnt[k] = 0; mFlag[k] = 0;
    end else begin
      mCnt[k] = 0;
    end
  endtask

  task automatic modelScan();
    bit found;
    for (int i = 0; i < ND; i++) begin
      if (sensorLat[i] >= 1 && sensorLat[i] <= TIMEOUT) begin
        if (!mPrimed[i]) mTemp[i] = int'(sensorData[i]);
        else mTemp[i] = mTemp[i] + floorDiv(int'(sensorData[i]) - mTemp[i], 1 << FS);
        mPrimed[i] = 1;
        mFault[i]  = 0;
      end else begin
        mFault[i] = 1;
      end
    end
    found = 0; mMax = 0; mIdx = 0;
    for (int i = 0; i < ND; i++) begin
      if (!mFault[i] && (!found || mTemp[i] > mMax)) begin
        mMax = mTemp[i]; mIdx = i; found = 1;
      end
    end
    mAllFault = !found;
    if (!found) begin
      mMax = 'hFFFF; mIdx = 0;
    end
    modelTracker(0, int'(warnThr));
    modelTracker(1, int'(critThr));
  endtask

  task automatic checkScan();
    for (int i = 0; i < ND; i++) begin
      checkOutput($sformatf("temperature%0d", i), 32'(temperature[i]), 32'(mTemp[i]));
      checkOutput($sformatf("fault%0d", i), 32'(sensor_fault[i]), 32'(mFault[i]));
    end
    checkOutput("temp_max", 32'(temp_max), 32'(mMax));
    checkOutput("temp_max_idx", 32'(temp_max_idx), 32'(mIdx));
    checkOutput("warning", 32'(thermal_warning), 32'(mFlag[0]));
    checkOutput("emergency", 32'(thermal_emergency), 32'(mFlag[1] | mAllFault));
  endtask

  task automatic checkResetState(input string pfx);
    for (int i = 0; i < ND; i++) begin
      checkOutput($sformatf("%s_temp%0d", pfx, i), 32'(temperature[i]), 0);
    end
    checkOutput({pfx, "_max"}, 32'(temp_max), 0);
    checkOutput({pfx, "_idx"}, 32'(temp_max_idx), 0);
    checkOutput({pfx, "_warn"}, 32'(thermal_warning), 0);
    checkOutput({pfx, "_emerg"}, 32'(thermal_emergency), 0);
    checkOutput({pfx, "_fault"}, 32'(sensor_fault), 0);
    checkOutput({pfx, "_done"}, 32'(scan_done), 0);
    checkOutput({pfx, "_req"}, 32'(sensIf.sens_req), 0);
    checkOutput({pfx, "_sel"}, 32'(sensIf.sens_sel), 0);
  endtask

  task automatic applyReset(input string pfx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState(pfx);
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [TW-1:0] val, input int lat);
    for (int i = 0; i < ND; i++) begin
      sensorData[i] = val;
      sensorLat[i]  = lat;
    end
  endtask

  task automatic waitScan();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 2000);
    if (scan_done !== 1'b1) begin
      checkOutput("scan_timeout", 0, 1);
    end else begin
      modelScan();
      checkScan();
      @(negedge clk);
      checkOutput("scan_done_pulse", 32'(scan_done), 0);
    end
  endtask

  task automatic waitReq();
    int n;
    n = 0;
    while (sensIf.sens_req !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sensIf.sens_req !== 1'b1) checkOutput("req_timeout", 0, 1);
  endtask

  // Sensor responder: answers each request after its configured latency.
  initial begin
    bit      pending;
    bit      prevReq;
    int      pendCnt;
    int      pendSel;
    pending = 0; prevReq = 0; pendCnt = 0; pendSel = 0;
    sensIf.sens_valid = 1'b0;
    sensIf.sens_data  = '0;
    forever begin
      @(negedge clk);
      sensIf.sens_valid = 1'b0;
      if (!rst_n) begin
        pending = 0;
        prevReq = 0;
      end else begin
        if (pending) begin
          pendCnt--;
          if (pendCnt == 0) begin
            checkOutput("sel_stable", 32'(sensIf.sens_sel), 32'(pendSel));
            sensIf.sens_valid = 1'b1;
            sensIf.sens_data  = sensorData[pendSel];
            pending = 0;
          end
        end
        if (sensIf.sens_req === 1'b1) begin
          checkOutput("req_one_cycle", 32'(prevReq), 0);
          reqCount++;
          if (sensorLat[sensIf.sens_sel] != 0) begin
            pending = 1;
            pendCnt = sensorLat[sensIf.sens_sel];
            pendSel = int'(sensIf.sens_sel);
          end
        end
        prevReq = sensIf.sens_req;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc;
    rst_n   = 1'b1;
    enable  = 1'b0;
    warnThr = 16'h4000;
    critThr = 16'h5800;
    applyStimulus(16'h3000, 2);
    modelReset();
    applyReset("reset");

    $display("[TB] prime and filter");
    enable = 1'b1;
    waitScan();
    checkOutput("prime_t0", 32'(temperature[0]), 32'h3000);
    checkOutput("prime_max", 32'(temp_max), 32'h3000);
    checkOutput("prime_idx", 32'(temp_max_idx), 0);
    sensorData[3] = 16'h3400;
    waitScan();
    checkOutput("filter_step1", 32'(temperature[3]), 32'h3100);
    waitScan();
    checkOutput("filter_step2", 32'(temperature[3]), 32'h31C0);
    checkOutput("filter_idx", 32'(temp_max_idx), 3);

    $display("[TB] persistence and hysteresis");
    applyStimulus(16'h5C00, 1);
    for (int i = 0; i < ND; i++) sensorLat[i] = $urandom_range(1, TIMEOUT);
    applyReset("reset2");
    for (int s = 1; s <= 4; s++) begin
      waitScan();
      if (s == 3) checkOutput("persist_scan3", 32'(thermal_emergency), 0);
    end
    checkOutput("persist_emerg4", 32'(thermal_emergency), 1);
    checkOutput("persist_warn4", 32'(thermal_warning), 1);
    applyStimulus(16'h5700, 3);
    repeat (6) waitScan();
    checkOutput("hyst_hold", 32'(thermal_emergency), 1);
    applyStimulus(16'h5500, 3);
    repeat (8) waitScan();
    checkOutput("hyst_clear", 32'(thermal_emergency), 0);

    $display("[TB] timeout");
    applyStimulus(16'h5000, 1);
    sensorData[5] = 16'h6000;
    sensorLat[5]  = 0;
    waitScan();
    checkOutput("timeout_fault5", 32'(sensor_fault[5]), 1);
    sensorLat[5] = TIMEOUT + 1;
    waitScan();
    checkOutput("late_fault5", 32'(sensor_fault[5]), 1);
    sensorLat[5] = TIMEOUT;
    waitScan();
    checkOutput("edge_fault5", 32'(sensor_fault[5]), 0);

    $display("[TB] random scans");
    for (int s = 0; s < 12; s++) begin
      if (s % 4 == 0) begin
        warnThr = TW'($urandom_range(16'h3000, 16'hB000));
        critThr = warnThr + TW'($urandom_range(0, 16'h1000));
      end
      for (int i = 0; i < ND; i++) begin
        int r;
        r = $urandom_range(0, 9);
        sensorLat[i]  = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
        sensorData[i] = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 16'hFFFF))
                                                    : critThr - TW'(16'h0400) + TW'($urandom_range(0, 16'h0800));
      end
      waitScan();
    end

    $display("[TB] all sensors silent");
    applyStimulus(16'h1000, 0);
    waitScan();
    checkOutput("allfault_max", 32'(temp_max), 32'hFFFF);
    checkOutput("allfault_idx", 32'(temp_max_idx), 0);
    checkOutput("allfault_emerg", 32'(thermal_emergency), 1);
    applyStimulus(16'h1000, 2);
    waitScan();

    $display("[TB] enable control");
    enable = 1'b0;
    rc = reqCount;
    repeat (150) @(negedge clk);
    checkOutput("idle_no_req", 32'(reqCount - rc), 0);
    enable = 1'b1;
    waitReq();
    enable = 1'b0;
    waitScan();
    rc = reqCount;
    repeat (150) @(negedge clk);
    checkOutput("stop_after_scan", 32'(reqCount - rc), 0);

    $display("[TB] reset mid-scan");
    applyStimulus(16'h2345, 4);
    enable = 1'b1;
    waitReq();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("midscan");
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitScan();
    checkOutput("reprime_t0", 32'(temperature[0]), 32'h2345);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
